// File: rtl/wb_forward_pipe.sv
// -----------------------------------------------------------------------------
// wb_forward_pipe
// Writeback-to-read bypass with a short history of retired writes.
// Each read port is served, newest first, from the write retiring this cycle,
// then from the retained history (entry 0 newest), else from the register file.
// Address 0 is never forwarded. Results are registered (1-cycle latency).
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wb_regwrite       writeback stage writes a register this cycle
//   wb_destadd        writeback destination address
//   wb_writedata      writeback data
//   flush             clear history valid bits and out_valid
//   rd_valid          read request present this cycle
//   stall             hold output stage; history only accepts new writes
//   rd_addr           packed read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rf_data           packed register-file read data, same packing
//   out_data          registered forwarded data
//   out_hit           registered per-port bypass flag
//   out_valid         out_data/out_hit valid
//   hit_count         saturating count of forwarded port reads
// -----------------------------------------------------------------------------
module wb_forward_pipe #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NPORTS = 2,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_regwrite,
    input  logic [ADDR_W-1:0]        wb_destadd,
    input  logic [DATA_W-1:0]        wb_writedata,
    input  logic                     flush,
    input  logic                     rd_valid,
    input  logic                     stall,
    input  logic [NPORTS*ADDR_W-1:0] rd_addr,
    input  logic [NPORTS*DATA_W-1:0] rf_data,
    output logic [NPORTS*DATA_W-1:0] out_data,
    output logic [NPORTS-1:0]        out_hit,
    output logic                     out_valid,
    output logic [15:0]              hit_count
);

    // Number of set bits in the per-port hit vector, widened for the adder.
    function automatic logic [16:0] f_popcount(input logic [NPORTS-1:0] v);
        logic [16:0] n;
        n = 17'd0;
        for (int i = 0; i < NPORTS; i++) begin
            n = n + {16'd0, v[i]};
        end
        return n;
    endfunction

    logic [DEPTH-1:0]        r_hv;
    logic [ADDR_W-1:0]       r_ha [DEPTH];
    logic [DATA_W-1:0]       r_hd [DEPTH];
    logic [NPORTS*DATA_W-1:0] r_out_data;
    logic [NPORTS-1:0]       r_out_hit;
    logic                    r_out_valid;
    logic [15:0]             r_hit_count;

    logic                     w_wq;
    logic [NPORTS*DATA_W-1:0] w_sel_data;
    logic [NPORTS-1:0]        w_sel_hit;
    logic [16:0]              w_sum;
    logic [15:0]              w_next_count;

    // Writes to register 0 are architecturally discarded, so they never qualify.
    assign w_wq = wb_regwrite && (wb_destadd != {ADDR_W{1'b0}});

    for (genvar gp = 0; gp < NPORTS; gp++) begin : g_port
        logic [ADDR_W-1:0] w_addr;
        logic [DATA_W-1:0] w_data;
        logic              w_hit;

        assign w_addr = rd_addr[gp*ADDR_W +: ADDR_W];

        // Per-port source select; scanning oldest to newest lets newer matches win.
        always_comb begin
            w_data = rf_data[gp*DATA_W +: DATA_W];
            w_hit  = 1'b0;
            if (w_addr != {ADDR_W{1'b0}}) begin
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (r_hv[i] && (r_ha[i] == w_addr)) begin
                        w_data = r_hd[i];
                        w_hit  = 1'b1;
                    end else begin
                        w_hit  = w_hit;
                    end
                end
                if (w_wq && (wb_destadd == w_addr)) begin
                    w_data = wb_writedata;
                    w_hit  = 1'b1;
                end else begin
                    w_hit  = w_hit;
                end
            end else begin
                w_hit = 1'b0;
            end
        end

        assign w_sel_data[gp*DATA_W +: DATA_W] = w_data;
        assign w_sel_hit[gp]                   = w_hit;
    end

    assign w_sum        = {1'b0, r_hit_count} + f_popcount(w_sel_hit);
    assign w_next_count = (w_sum > 17'h0FFFF) ? 16'hFFFF : w_sum[15:0];

    // History shift register; a stall freezes it except when a write retires,
    // so retiring writes are never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hv <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_ha[i] <= {ADDR_W{1'b0}};
                r_hd[i] <= {DATA_W{1'b0}};
            end
        end else if (flush) begin
            r_hv <= {DEPTH{1'b0}};
        end else if (!stall || w_wq) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                r_hv[i] <= r_hv[i-1];
                r_ha[i] <= r_ha[i-1];
                r_hd[i] <= r_hd[i-1];
            end
            r_hv[0] <= w_wq;
            r_ha[0] <= wb_destadd;
            r_hd[0] <= wb_writedata;
        end else begin
            r_hv <= r_hv;
        end
    end

    // Output stage and hit counter; flush beats stall, stall beats capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= {(NPORTS*DATA_W){1'b0}};
            r_out_hit   <= {NPORTS{1'b0}};
            r_out_valid <= 1'b0;
            r_hit_count <= 16'd0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (stall) begin
            r_out_valid <= r_out_valid;
        end else if (rd_valid) begin
            r_out_data  <= w_sel_data;
            r_out_hit   <= w_sel_hit;
            r_out_valid <= 1'b1;
            r_hit_count <= w_next_count;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_hit   = r_out_hit;
    assign out_valid = r_out_valid;
    assign hit_count = r_hit_count;

endmodule

// File: tb/tb_wb_forward_pipe.sv
module tb_wb_forward_pipe;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NP = 2;
    localparam int DP = 2;

    logic              clk;
    logic              rst;
    logic              wb_regwrite;
    logic [AW-1:0]     wb_destadd;
    logic [DW-1:0]     wb_writedata;
    logic              flush;
    logic              rd_valid;
    logic              stall;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rf_data;
    logic [NP*DW-1:0]  out_data;
    logic [NP-1:0]     out_hit;
    logic              out_valid;
    logic [15:0]       hit_count;

    typedef struct {
        logic [NP*DW-1:0] data;
        logic [NP-1:0]    hit;
        logic [15:0]      cnt;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    wb_forward_pipe #(.DATA_W(DW), .ADDR_W(AW), .NPORTS(NP), .DEPTH(DP)) dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_destadd(wb_destadd), .wb_writedata(wb_writedata),
        .flush(flush), .rd_valid(rd_valid), .stall(stall),
        .rd_addr(rd_addr), .rf_data(rf_data),
        .out_data(out_data), .out_hit(out_hit), .out_valid(out_valid), .hit_count(hit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_regwrite = 1'b0; wb_destadd = 5'd0; wb_writedata = 32'd0;
        flush = 1'b0; rd_valid = 1'b0; stall = 1'b0;
        rd_addr = '0; rf_data = '0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_regwrite = 1'b1; wb_destadd = a; wb_writedata = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [DW-1:0] f0,
                      input logic [AW-1:0] a1, input logic [DW-1:0] f1);
        rd_valid = 1'b1; rd_addr = {a1, a0}; rf_data = {f1, f0};
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        rd_valid = 1'b1; wr(5'd4, 32'h44); rd(5'd4, 32'h1, 5'd4, 32'h2);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
        checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_count got=%0h want=0", hit_count); end
        checks++; if (out_hit !== 2'b00) begin errors++; $display("FAIL reset_hit got=%b want=00", out_hit); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_data got=%h want=0", out_data); end
        #3 rst = 1'b0;
        idle();
        tick();
        // the r4 write held during reset must not be in history
        rd(5'd4, 32'hCAFE, 5'd0, 32'h0);
        sb.push_back('{data: {32'h0, 32'hCAFE}, hit: 2'b00, cnt: 16'd0});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit || out_valid !== 1'b1)
            begin errors++; $display("FAIL reset_ignore got=%h/%b want=%h/%b", out_data, out_hit, e.data, e.hit); end
    endtask

    task automatic test_fwd_current();
        wr(5'd5, 32'hAAAA0001);
        rd(5'd5, 32'h0, 5'd6, 32'h1234);
        sb.push_back('{data: {32'h1234, 32'hAAAA0001}, hit: 2'b01, cnt: 16'd1});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data) begin errors++; $display("FAIL cur_data got=%h want=%h", out_data, e.data); end
        checks++; if (out_hit !== e.hit) begin errors++; $display("FAIL cur_hit got=%b want=%b", out_hit, e.hit); end
        checks++; if (hit_count !== e.cnt) begin errors++; $display("FAIL cur_count got=%0d want=%0d", hit_count, e.cnt); end
    endtask

    task automatic test_newest();
        wr(5'd7, 32'h11);
        tick(); idle();
        checks++; if (out_valid !== 1'b0 || out_data !== {32'h1234, 32'hAAAA0001})
            begin errors++; $display("FAIL idle_hold got=%0b/%h want=0/%h", out_valid, out_data, {32'h1234, 32'hAAAA0001}); end
        wr(5'd7, 32'h22);
        tick(); idle();
        rd(5'd7, 32'hDEAD, 5'd7, 32'hBEEF);
        sb.push_back('{data: {32'h22, 32'h22}, hit: 2'b11, cnt: 16'd3});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit)
            begin errors++; $display("FAIL newest got=%h/%b want=%h/%b", out_data, out_hit, e.data, e.hit); end
        checks++; if (hit_count !== e.cnt) begin errors++; $display("FAIL newest_count got=%0d want=%0d", hit_count, e.cnt); end
    endtask

    task automatic test_aged();
        wr(5'd3, 32'h33); tick();
        wr(5'd10, 32'hA0); tick();
        wr(5'd11, 32'hB0); tick();
        wr(5'd12, 32'hC0); tick();
        idle();
        rd(5'd3, 32'h33330000, 5'd11, 32'h0);
        sb.push_back('{data: {32'hB0, 32'h33330000}, hit: 2'b10, cnt: 16'd4});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit)
            begin errors++; $display("FAIL aged got=%h/%b want=%h/%b", out_data, out_hit, e.data, e.hit); end
        checks++; if (hit_count !== e.cnt) begin errors++; $display("FAIL aged_count got=%0d want=%0d", hit_count, e.cnt); end
    endtask

    task automatic test_r0();
        wr(5'd0, 32'hFFFF);
        rd(5'd0, 32'h0, 5'd0, 32'h0);
        sb.push_back('{data: 64'd0, hit: 2'b00, cnt: 16'd4});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit || hit_count !== e.cnt)
            begin errors++; $display("FAIL r0 got=%h/%b/%0d want=%h/%b/%0d", out_data, out_hit, hit_count, e.data, e.hit, e.cnt); end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1;
        wr(5'd9, 32'h99);
        rd(5'd9, 32'h1, 5'd9, 32'h1);
        tick();
        wb_regwrite = 1'b0;
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 64'd0 || hit_count !== 16'd4)
            begin errors++; $display("FAIL stall_hold got=%0b/%h/%0d want=1/0/4", out_valid, out_data, hit_count); end
        idle();
        rd(5'd9, 32'h5, 5'd0, 32'h6);
        sb.push_back('{data: {32'h6, 32'h99}, hit: 2'b01, cnt: 16'd5});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit || hit_count !== e.cnt)
            begin errors++; $display("FAIL stall_write got=%h/%b/%0d want=%h/%b/%0d", out_data, out_hit, hit_count, e.data, e.hit, e.cnt); end
        wr(5'd9, 32'h77); tick(); idle();
        flush = 1'b1; rd(5'd9, 32'h1, 5'd9, 32'h1);
        tick(); idle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
        rd(5'd9, 32'h5, 5'd9, 32'h8);
        sb.push_back('{data: {32'h8, 32'h5}, hit: 2'b00, cnt: 16'd5});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit || hit_count !== e.cnt)
            begin errors++; $display("FAIL flush_read got=%h/%b/%0d want=%h/%b/%0d", out_data, out_hit, hit_count, e.data, e.hit, e.cnt); end
    endtask

    task automatic test_back_to_back();
        for (int k = 1; k <= 4; k++) begin
            wr(5'd20, 32'(k * 16'h0101));
            rd(5'd20, 32'hF0, 5'd21, 32'(k));
            sb.push_back('{data: {32'(k), 32'(k * 16'h0101)}, hit: 2'b01, cnt: 16'(5 + k)});
            tick();
            e = sb.pop_front();
            checks++; if (out_data !== e.data || out_hit !== e.hit || hit_count !== e.cnt || out_valid !== 1'b1)
                begin errors++; $display("FAIL b2b_%0d got=%h/%b/%0d want=%h/%b/%0d", k, out_data, out_hit, hit_count, e.data, e.hit, e.cnt); end
        end
        idle();
        tick();
    endtask

    task automatic test_saturate_reset();
        for (int c = 0; c < 32800; c++) begin
            wr(5'd1, 32'(c));
            rd(5'd1, 32'h0, 5'd1, 32'h0);
            tick();
        end
        checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL saturate got=%h want=ffff", hit_count); end
        idle();
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || hit_count !== 16'd0 || out_hit !== 2'b00)
            begin errors++; $display("FAIL async_rst got=%0b/%h/%b want=0/0/00", out_valid, hit_count, out_hit); end
        #1 rst = 1'b0;
        rd(5'd1, 32'h5A5A, 5'd1, 32'hA5A5);
        sb.push_back('{data: {32'hA5A5, 32'h5A5A}, hit: 2'b00, cnt: 16'd0});
        tick(); idle();
        e = sb.pop_front();
        checks++; if (out_data !== e.data || out_hit !== e.hit || hit_count !== e.cnt)
            begin errors++; $display("FAIL rst_history got=%h/%b/%0d want=%h/%b/%0d", out_data, out_hit, hit_count, e.data, e.hit, e.cnt); end
    endtask

    initial begin
        test_reset();
        test_fwd_current();
        test_newest();
        test_aged();
        test_r0();
        test_stall_flush();
        test_back_to_back();
        test_saturate_reset();
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got=%0d want=0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_forward_pipe.md
WB_FORWARD_PIPE -- requirements
Module: wb_forward_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width.
REQ-003 SHALL have parameter NPORTS, default 2, number of read ports forwarded.
REQ-004 SHALL have parameter DEPTH, default 2, number of retired writes retained in history (1..4).
REQ-005 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-007 SHALL have port wb_regwrite  input  1  writeback stage writes a register this cycle.
REQ-008 SHALL have port wb_destadd  input  ADDR_W  writeback destination address.
REQ-009 SHALL have port wb_writedata  input  DATA_W  writeback data.
REQ-010 SHALL have port flush  input  1  clear history and output stage.
REQ-011 SHALL have port rd_valid  input  1  read request present this cycle.
REQ-012 SHALL have port stall  input  1  hold output stage and history.
REQ-013 SHALL have port rd_addr  input  NPORTS*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W].
REQ-014 SHALL have port rf_data  input  NPORTS*DATA_W  register-file read data, same packing.
REQ-015 SHALL have port out_data  output  NPORTS*DATA_W  registered forwarded data.
REQ-016 SHALL have port out_hit  output  NPORTS  registered per-port flag, data came from bypass.
REQ-017 SHALL have port out_valid  output  1  out_data/out_hit valid.
REQ-018 SHALL have port hit_count  output  16  saturating count of forwarded port reads.

Function
REQ-019 SHALL treat a write as qualifying only when wb_regwrite=1 and wb_destadd!=0.
REQ-020 SHALL keep a DEPTH-entry history (valid, addr, data); on each unstalled edge a qualifying write enters entry 0 and entries shift toward DEPTH-1, oldest dropped; non-qualifying cycle shifts in an invalid entry.
REQ-021 SHALL select per port, priority newest first: current qualifying write, then history entry 0..DEPTH-1, else rf_data.
REQ-022 SHALL never forward for rd_addr=0; port returns rf_data, hit=0.
REQ-023 SHALL, on an edge with rd_valid=1 and stall=0, register selected data into out_data, hit flags into out_hit, set out_valid=1 (latency 1 cycle).
REQ-024 SHALL, on an edge with rd_valid=0 and stall=0, clear out_valid; out_data/out_hit hold.
REQ-025 SHALL, when stall=1, hold out_data, out_hit, out_valid and history unchanged, while a qualifying write still updates history (writes are never lost).
REQ-026 SHALL, when flush=1, clear all history valid bits and out_valid on that edge, overriding stall and rd_valid; hit_count unaffected.
REQ-027 SHALL increment hit_count by popcount of hits registered on each REQ-023 capture, saturating at 16'hFFFF.
REQ-028 SHALL, when multiple history entries match, use the newest.

Reset
REQ-029 SHALL on rst=1 asynchronously clear history valid, out_valid, out_hit, out_data and hit_count to 0.
REQ-030 SHALL ignore rd_valid, wb_regwrite and flush while rst=1; first capture on first rising edge after deassertion.

Verification
REQ-031 SHALL cover: write r5=0xAAAA0001 with rd_addr port0=5, rf_data=0 -> next cycle out_data[0]=0xAAAA0001, out_hit[0]=1, hit_count=1.
REQ-032 SHALL cover: write r7=0x11 cycle N, r7=0x22 cycle N+1, read r7 cycle N+2 with no write -> out_data=0x22 (newest history entry).
REQ-033 SHALL cover: write r3 then DEPTH+1 writes to other regs, read r3 -> out_data=rf_data, out_hit=0 (aged out).
REQ-034 SHALL cover: write r0=0xFFFF, read r0 both ports with rf_data=0 -> out_data=0, out_hit=0.
REQ-035 SHALL cover: stall=1 for 3 cycles with write r9=0x99, then stall=0 and read r9 -> out_data=0x99; flush before read -> out_hit=0.
REQ-036 SHALL cover: rst asserted mid-stream between clock edges -> out_valid, hit_count, history cleared immediately; hit_count saturation held at 0xFFFF.
